// File: rtl/tfg_pkg.sv
// Shared types and helpers for the twiddle-stream sink: FSM state encoding,
// counter/stage widths and the beats-per-stage calculation.
package tfg_pkg;

    localparam int STAGE_W = 5;
    localparam int CNT_W   = 16;
    localparam int LOG2N_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_RUN    = 2'd2,
        ST_DONE   = 2'd3
    } tfg_state_e;

    // Beats per stage: one beat covers 2^lanes_log2 twiddles, never fewer than one beat.
    function automatic logic [CNT_W-1:0] beats_per_stage(
        input logic [LOG2N_W-1:0] l,
        input logic [LOG2N_W-1:0] lanes_log2
    );
        logic [CNT_W-1:0] b;
        if (l >= lanes_log2) b = CNT_W'(1) << (l - lanes_log2);
        else                 b = CNT_W'(1);
        return b;
    endfunction

endpackage

// File: rtl/tfg_stream_sink_if.sv
// Control and twiddle-stream signals between the sink, its twiddle source
// and the butterfly array; master drives the i_* side, slave is the sink.
interface tfg_stream_sink_if #(
    parameter int N    = 16,
    parameter int TF_W = 32
);
    import tfg_pkg::*;

    logic                  i_start;
    logic [LOG2N_W-1:0]    i_log2N;
    logic                  o_tfg_valid;
    logic [LOG2N_W-1:0]    o_tfg_log2N;
    logic                  i_tf_valid;
    logic [N*TF_W-1:0]     i_tf_data;
    logic                  i_bf_ready;
    logic                  o_bf_valid;
    logic [N*TF_W-1:0]     o_bf_tf;
    logic                  o_last_beat;
    logic [STAGE_W-1:0]    o_stage;
    logic                  o_busy;
    logic                  o_done;
    logic                  o_err;

    modport master (
        output i_start, i_log2N, i_tf_valid, i_tf_data, i_bf_ready,
        input  o_tfg_valid, o_tfg_log2N, o_bf_valid, o_bf_tf, o_last_beat,
               o_stage, o_busy, o_done, o_err
    );

    modport slave (
        input  i_start, i_log2N, i_tf_valid, i_tf_data, i_bf_ready,
        output o_tfg_valid, o_tfg_log2N, o_bf_valid, o_bf_tf, o_last_beat,
               o_stage, o_busy, o_done, o_err
    );

endinterface

// File: rtl/tfg_sink_fifo.sv
// Synchronous first-word-fall-through FIFO; a word written at one edge is
// on dout in the following cycle. Storage is not reset, only pointers.
module tfg_sink_fifo #(
    parameter int W     = 512,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [W-1:0]             din,
    input  logic                     pop,
    output logic [W-1:0]             dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   cnt;
    logic          do_push;
    logic          do_pop;

    assign full    = (cnt == (AW+1)'(DEPTH));
    assign empty   = (cnt == '0);
    assign count   = cnt;
    assign dout    = mem[rd_ptr];
    assign do_pop  = pop && !empty;
    // A full FIFO still accepts a write when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/tfg_stream_sink.sv
// Twiddle-stream sink: launches the twiddle generator, buffers its beats and
// feeds them stage by stage to the butterfly array. TFG_SINK_ERR_EN enables o_err.
module tfg_stream_sink
    import tfg_pkg::*;
#(
    parameter int N     = 16,
    parameter int TF_W  = 32,
    parameter int DEPTH = 16
) (
    input  logic               clk,
    input  logic               rst,
    tfg_stream_sink_if.slave   bus
);

    localparam int                 W          = N * TF_W;
    localparam logic [LOG2N_W-1:0] LANES_LOG2 = LOG2N_W'($clog2(N));

    tfg_state_e              state;
    logic [LOG2N_W-1:0]      log2n_q;
    logic [CNT_W-1:0]        rx_cnt;
    logic [CNT_W-1:0]        pop_cnt;
    logic [CNT_W-1:0]        beat_cnt;
    logic [CNT_W-1:0]        beats;
    logic [CNT_W-1:0]        total;
    logic [STAGE_W-1:0]      stage_q;
    logic                    start_acc;
    logic                    pop;
    logic                    push;
    logic                    last_pop;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic [$clog2(DEPTH):0]  fifo_count;
    logic [W-1:0]            fifo_dout;

    assign beats     = beats_per_stage(log2n_q, LANES_LOG2);
    assign total     = (CNT_W'(log2n_q) + CNT_W'(1)) * beats;
    assign start_acc = (state == ST_IDLE) && bus.i_start;

    assign bus.o_bf_valid  = (state == ST_RUN) && (fifo_count != '0);
    assign pop             = bus.o_bf_valid && bus.i_bf_ready;
    // Beats past the transform total, or with no room left, are discarded.
    assign push            = (state == ST_RUN) && bus.i_tf_valid && (rx_cnt < total)
                             && (!fifo_full || pop);
    assign last_pop        = pop && (pop_cnt == total - 1'b1);
    assign bus.o_last_beat = bus.o_bf_valid && (beat_cnt == beats - 1'b1);

    tfg_sink_fifo #(
        .W     (W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (bus.i_tf_data),
        .pop   (pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_IDLE;
            log2n_q  <= '0;
            rx_cnt   <= '0;
            pop_cnt  <= '0;
            beat_cnt <= '0;
            stage_q  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_acc) begin
                        state    <= ST_LAUNCH;
                        log2n_q  <= bus.i_log2N;
                        rx_cnt   <= '0;
                        pop_cnt  <= '0;
                        beat_cnt <= '0;
                    end
                end
                ST_LAUNCH: begin
                    state   <= ST_RUN;
                    stage_q <= STAGE_W'(log2n_q);
                end
                ST_RUN:  if (last_pop) state <= ST_DONE;
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase

            if (push) rx_cnt <= rx_cnt + 1'b1;
            if (pop) begin
                pop_cnt <= pop_cnt + 1'b1;
                if (bus.o_last_beat) begin
                    beat_cnt <= '0;
                    if (stage_q != '0) stage_q <= stage_q - 1'b1;
                end else begin
                    beat_cnt <= beat_cnt + 1'b1;
                end
            end
        end
    end

`ifdef TFG_SINK_ERR_EN
    logic err_q;
    logic drop;

    assign drop = bus.i_tf_valid && !push;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)           err_q <= 1'b0;
        else if (start_acc) err_q <= drop;
        else if (drop)      err_q <= 1'b1;
    end

    assign bus.o_err = err_q;
`else
    assign bus.o_err = 1'b0;
`endif

    assign bus.o_tfg_valid = (state == ST_LAUNCH);
    assign bus.o_tfg_log2N = log2n_q;
    assign bus.o_stage     = stage_q;
    assign bus.o_busy      = (state != ST_IDLE);
    assign bus.o_done      = (state == ST_DONE);
    assign bus.o_bf_tf     = fifo_empty ? '0 : fifo_dout;

endmodule

// File: tb/tb_tfg_stream_sink.sv
// Bench for tfg_stream_sink: table of transforms, hand sequences for overflow,
// full push/pop, ignored start and mid-run reset, then randomized transforms.
module tb_tfg_stream_sink;
    import tfg_pkg::*;

    localparam int N = 16, TF_W = 32, DEPTH = 16, W = N * TF_W, LG = 4;
`ifdef TFG_SINK_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    tfg_stream_sink_if #(.N(N), .TF_W(TF_W)) bus ();

    tfg_stream_sink #(.N(N), .TF_W(TF_W), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct {
        int l;
        int vpct;
        int rpct;
        int exp_t;
    } vec_t;

    vec_t vecs [6];

    int tests = 0;
    int fails = 0;

    int           m_phase;
    int           m_l;
    logic [W-1:0] m_q [$];
    int           m_rx;
    int           m_pops;
    bit           m_err;

    int obs_pops, obs_last, obs_done, first_stage, done_log2n;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_data(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] rnd_data();
        logic [W-1:0] d;
        for (int i = 0; i < W / 32; i++) d[i*32 +: 32] = $urandom;
        return d;
    endfunction

    function automatic int m_b();
        return (m_l >= LG) ? (1 << (m_l - LG)) : 1;
    endfunction

    function automatic int m_t();
        return ((m_l + 1) * m_b()) & 16'hffff;
    endfunction

    function automatic bit e_valid();
        return (m_phase == 2) && (m_q.size() > 0);
    endfunction

    task automatic model_reset();
        m_phase = 0; m_l = 0; m_q.delete(); m_rx = 0; m_pops = 0; m_err = 0;
    endtask

    task automatic compare_all();
        bit           ev;
        int           b;
        int           s;
        logic [W-1:0] ed;
        ev = e_valid();
        b  = m_b();
        s  = m_l - m_pops / b;
        if (s < 0 || m_phase != 2) s = 0;
        if (ev) ed = m_q[0];
        else    ed = '0;
        chk("tfg_valid", bus.o_tfg_valid, m_phase == 1);
        chk("busy",      bus.o_busy,      m_phase != 0);
        chk("done",      bus.o_done,      m_phase == 3);
        chk("bf_valid",  bus.o_bf_valid,  ev);
        chk("last_beat", bus.o_last_beat, ev && ((m_pops % b) == b - 1));
        chk("stage",     bus.o_stage,     s);
        chk("tfg_log2N", bus.o_tfg_log2N, m_l);
        chk("err",       bus.o_err,       ERR_EN ? m_err : 1'b0);
        chk_data("bf_tf", bus.o_bf_tf, ed);
    endtask

    task automatic model_step();
        bit pop, push, start_acc, was_last, drop;
        int t;
        if (!rst) begin
            model_reset();
            return;
        end
        t         = m_t();
        pop       = e_valid() && bus.i_bf_ready;
        push      = (m_phase == 2) && bus.i_tf_valid && (m_rx < t) && (m_q.size() < DEPTH || pop);
        drop      = bus.i_tf_valid && !push;
        start_acc = (m_phase == 0) && bus.i_start;
        was_last  = pop && (m_pops == t - 1);
        if (start_acc) m_err = drop;
        else if (drop) m_err = 1'b1;
        if (pop) begin
            void'(m_q.pop_front());
            m_pops++;
        end
        if (push) begin
            m_q.push_back(bus.i_tf_data);
            m_rx++;
        end
        case (m_phase)
            0: if (start_acc) begin
                   m_phase = 1; m_l = int'(bus.i_log2N); m_rx = 0; m_pops = 0;
               end
            1: m_phase = 2;
            2: if (was_last) m_phase = 3;
            default: m_phase = 0;
        endcase
    endtask

    task automatic observe();
        if (bus.o_bf_valid && bus.i_bf_ready) begin
            obs_pops++;
            if (bus.o_last_beat) obs_last++;
            if (obs_pops == 1) first_stage = int'(bus.o_stage);
        end
        if (bus.o_done) begin
            obs_done++;
            done_log2n = int'(bus.o_tfg_log2N);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        compare_all();
        observe();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_obs();
        obs_pops = 0; obs_last = 0; obs_done = 0; first_stage = -1; done_log2n = -1;
    endtask

    task automatic idle_inputs();
        bus.i_start = 0; bus.i_log2N = '0; bus.i_tf_valid = 0; bus.i_tf_data = '0; bus.i_bf_ready = 0;
    endtask

    // Start a transform and step through LAUNCH so the next tick is in RUN.
    task automatic start_xfer(input int l);
        clear_obs();
        bus.i_start = 1; bus.i_log2N = 4'(l); bus.i_tf_valid = 0; bus.i_bf_ready = 0;
        tick();
        bus.i_start = 0;
        tick();
    endtask

    task automatic finish_xfer(input int vpct, input int rpct, input string name);
        int cyc = 0;
        while (m_phase != 0 && cyc < 3000) begin
            bus.i_tf_valid = ($urandom_range(99) < vpct);
            bus.i_tf_data  = rnd_data();
            bus.i_bf_ready = ($urandom_range(99) < rpct);
            tick();
            cyc++;
        end
        chk({name, "_completes"}, m_phase == 0, 1'b1);
        bus.i_tf_valid = 0; bus.i_bf_ready = 0;
    endtask

    task automatic check_obs(input string name, input int l, input int exp_t);
        chk({name, "_pops"},       obs_pops,    exp_t);
        chk({name, "_last_beats"}, obs_last,    l + 1);
        chk({name, "_first_stage"}, first_stage, l);
        chk({name, "_done_pulses"}, obs_done,   1);
        chk({name, "_done_log2N"}, done_log2n,  l);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{4, 100, 100, 5};
        vecs[1] = '{6, 100, 100, 28};
        vecs[2] = '{2, 100, 100, 3};
        vecs[3] = '{5,  80,  60, 12};
        vecs[4] = '{7,  90,  70, 64};
        vecs[5] = '{3,  50,  50, 4};

        idle_inputs();
        model_reset();
        #1;
        compare_all();
        tick();
        tick();
        rst = 1;

        for (int i = 0; i < 6; i++) begin
            start_xfer(vecs[i].l);
            finish_xfer(vecs[i].vpct, vecs[i].rpct, "vec");
            check_obs("vec", vecs[i].l, vecs[i].exp_t);
            tick();
        end

        // Overflow: 17 beats with the butterfly stalled, one must be dropped.
        start_xfer(6);
        for (int i = 0; i < 17; i++) begin
            bus.i_tf_valid = 1; bus.i_tf_data = rnd_data(); bus.i_bf_ready = 0;
            tick();
        end
        bus.i_tf_valid = 0;
        chk("overflow_err", bus.o_err, ERR_EN);
        chk("overflow_valid", bus.o_bf_valid, 1'b1);
        for (int i = 0; i < 16; i++) begin
            bus.i_bf_ready = 1;
            tick();
        end
        bus.i_bf_ready = 0;
        chk("overflow_drained16", bus.o_bf_valid, 1'b0);
        finish_xfer(100, 100, "overflow");
        check_obs("overflow", 6, 28);

        // Full FIFO, then simultaneous push and pop.
        start_xfer(6);
        for (int i = 0; i < 16; i++) begin
            bus.i_tf_valid = 1; bus.i_tf_data = rnd_data(); bus.i_bf_ready = 0;
            tick();
        end
        bus.i_tf_valid = 1; bus.i_tf_data = rnd_data(); bus.i_bf_ready = 1;
        tick();
        bus.i_tf_valid = 0; bus.i_bf_ready = 0;
        chk("pushpop_err", bus.o_err, 1'b0);
        for (int i = 0; i < 16; i++) begin
            bus.i_bf_ready = 1;
            tick();
        end
        bus.i_bf_ready = 0;
        chk("pushpop_drained16", bus.o_bf_valid, 1'b0);
        finish_xfer(100, 100, "pushpop");

        // Start while running is ignored; reset mid-run aborts.
        start_xfer(4);
        bus.i_tf_valid = 1; bus.i_bf_ready = 1; bus.i_tf_data = rnd_data();
        tick();
        bus.i_start = 1; bus.i_log2N = 4'd9; bus.i_tf_data = rnd_data();
        tick();
        bus.i_start = 0;
        chk("ignored_start_log2N", bus.o_tfg_log2N, 4);
        chk("ignored_start_busy", bus.o_busy, 1'b1);
        rst = 0;
        idle_inputs();
        #1;
        chk("rst_tfg_valid", bus.o_tfg_valid, 1'b0);
        chk("rst_bf_valid",  bus.o_bf_valid, 1'b0);
        chk("rst_last_beat", bus.o_last_beat, 1'b0);
        chk("rst_busy",      bus.o_busy, 1'b0);
        chk("rst_done",      bus.o_done, 1'b0);
        chk("rst_err",       bus.o_err, 1'b0);
        chk("rst_stage",     bus.o_stage, 0);
        chk("rst_log2N",     bus.o_tfg_log2N, 0);
        chk_data("rst_bf_tf", bus.o_bf_tf, '0);
        model_reset();
        tick();
        tick();
        rst = 1;
        tick();
        start_xfer(4);
        finish_xfer(100, 100, "after_rst");
        check_obs("after_rst", 4, 5);

        // Randomized transforms with stray beats between them.
        for (int k = 0; k < 8; k++) begin
            int l;
            l = $urandom_range(1, 6);
            for (int j = 0; j < 3; j++) begin
                bus.i_tf_valid = $urandom_range(1); bus.i_tf_data = rnd_data();
                tick();
            end
            bus.i_tf_valid = 0;
            start_xfer(l);
            finish_xfer($urandom_range(30, 100), $urandom_range(20, 100), "rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
